// File: rtl/dim_frame_sequencer.sv
// dim_frame_sequencer: frame/zone timing for the backlight-dimming pixel path.
// Tracks VSYNC/DE on the output pixel clock, assigns each active pixel to a
// backlight zone, strobes the per-zone statistics datapath and applies the
// pass/maker mode only at frame start.
//
// state   | meaning
// --------+--------------------------------------------------------------
// WAIT_VS | after reset, no frame timing known; nothing is accumulated
// ARMED   | frame started, waiting for the first DE line
// ACTIVE  | counting pixels and lines of the active picture
// DONE    | all V_ACTIVE lines seen; further DE lines are errors
module dim_frame_sequencer #(
  parameter int ZONE_W  = 128,
  parameter int ZONE_H  = 192,
  parameter int ZONES_X = 8,
  parameter int ZONES_Y = 4,
  parameter bit VS_POL  = 1'b1
) (
  input  logic                                iODCK,
  input  logic                                reset,
  input  logic                                iDE,
  input  logic                                iHSYNC,
  input  logic                                iVSYNC,
  input  logic                                iSW1pass0maker,
  output logic                                oMode,
  output logic                                oAccEn,
  output logic [$clog2(ZONES_X)-1:0]          oZoneX,
  output logic [$clog2(ZONES_Y)-1:0]          oZoneY,
  output logic [$clog2(ZONES_X*ZONES_Y)-1:0]  oZoneIdx,
  output logic                                oRowLatch,
  output logic                                oFrameDone,
  output logic                                oErr
);

  localparam int H_ACTIVE = ZONE_W * ZONES_X;
  localparam int V_ACTIVE = ZONE_H * ZONES_Y;
  localparam int XW  = $clog2(ZONES_X);
  localparam int YW  = $clog2(ZONES_Y);
  localparam int IW  = $clog2(ZONES_X * ZONES_Y);
  // Pixel counter has headroom above H_ACTIVE so long lines are visible.
  localparam int PW  = $clog2(H_ACTIVE) + 2;
  localparam int LW  = $clog2(V_ACTIVE) + 1;
  localparam int SXW = (ZONE_W > 1) ? $clog2(ZONE_W) : 1;
  localparam int SYW = (ZONE_H > 1) ? $clog2(ZONE_H) : 1;

  localparam logic [PW-1:0]  H_LIM   = PW'(H_ACTIVE);
  localparam logic [LW-1:0]  V_LIM   = LW'(V_ACTIVE);
  localparam logic [LW-1:0]  V_LAST  = LW'(V_ACTIVE - 1);
  localparam logic [SXW-1:0] XS_LAST = SXW'(ZONE_W - 1);
  localparam logic [SYW-1:0] YS_LAST = SYW'(ZONE_H - 1);
  localparam logic [XW-1:0]  ZX_LAST = XW'(ZONES_X - 1);
  localparam logic [YW-1:0]  ZY_LAST = YW'(ZONES_Y - 1);

  typedef enum logic [1:0] {WAIT_VS, ARMED, ACTIVE, DONE} state_t;

  state_t         state;
  logic           de_r, de_d, hs_r, hs_d, vs_r, vs_act_d, sw_r;
  logic [PW-1:0]  pix_cnt;
  logic [SXW-1:0] xsub;
  logic [XW-1:0]  zx;
  logic [LW-1:0]  line_cnt;
  logic [SYW-1:0] ysub;
  logic [YW-1:0]  zy;

  logic           vs_act, fs, de_rise, de_fall, pix_go;
  logic [PW-1:0]  pix_b;
  logic [SXW-1:0] xsub_b;
  logic [XW-1:0]  zx_b;
  logic [LW-1:0]  line_b;
  logic [YW-1:0]  zy_b;
  logic [IW-1:0]  idx_b;

  // Edge detection on the registered inputs.
  assign vs_act  = (vs_r == VS_POL);
  assign fs      = vs_act && !vs_act_d;
  assign de_rise = de_r && !de_d;
  assign de_fall = !de_r && de_d;

  // A DE cycle coinciding with fs is pixel 0 of the new frame, so the
  // counters it sees are the cleared ones.
  assign pix_go = de_r && (fs || (state == ACTIVE) || ((state == ARMED) && de_rise));
  assign pix_b  = fs ? '0 : pix_cnt;
  assign xsub_b = fs ? '0 : xsub;
  assign zx_b   = fs ? '0 : zx;
  assign line_b = fs ? '0 : line_cnt;
  assign zy_b   = fs ? '0 : zy;
  assign idx_b  = IW'(zy_b) * IW'(ZONES_X) + IW'(zx_b);

  // Input registers, sequencer FSM, counters and registered outputs.
  always_ff @(posedge iODCK or posedge reset) begin
    if (reset) begin
      de_r       <= 1'b0;
      de_d       <= 1'b0;
      hs_r       <= 1'b0;
      hs_d       <= 1'b0;
      // Treat VSYNC as already active so a sync in progress is not an edge.
      vs_r       <= VS_POL;
      vs_act_d   <= 1'b1;
      sw_r       <= 1'b1;
      state      <= WAIT_VS;
      pix_cnt    <= '0;
      xsub       <= '0;
      zx         <= '0;
      line_cnt   <= '0;
      ysub       <= '0;
      zy         <= '0;
      oMode      <= 1'b1;
      oAccEn     <= 1'b0;
      oZoneX     <= '0;
      oZoneY     <= '0;
      oZoneIdx   <= '0;
      oRowLatch  <= 1'b0;
      oFrameDone <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      de_r       <= iDE;
      de_d       <= de_r;
      hs_r       <= iHSYNC;
      hs_d       <= hs_r;
      vs_r       <= iVSYNC;
      vs_act_d   <= vs_act;
      sw_r       <= iSW1pass0maker;
      oAccEn     <= 1'b0;
      oRowLatch  <= 1'b0;
      oFrameDone <= 1'b0;

      if (fs) begin
        oMode    <= sw_r;
        // A frame cut short is reported against the frame that follows.
        oErr     <= (state == ACTIVE);
        pix_cnt  <= '0;
        xsub     <= '0;
        zx       <= '0;
        line_cnt <= '0;
        ysub     <= '0;
        zy       <= '0;
        oZoneX   <= '0;
        oZoneY   <= '0;
        oZoneIdx <= '0;
        state    <= de_r ? ACTIVE : ARMED;
      end else begin
        case (state)
          WAIT_VS: ;
          ARMED: begin
            if (de_rise) state <= ACTIVE;
          end
          ACTIVE: begin
            if (de_fall) begin
              if (pix_cnt != H_LIM) oErr <= 1'b1;
              pix_cnt  <= '0;
              xsub     <= '0;
              zx       <= '0;
              line_cnt <= line_cnt + 1'b1;
              if (ysub == YS_LAST) begin
                ysub      <= '0;
                oRowLatch <= 1'b1;
                if (zy != ZY_LAST) zy <= zy + 1'b1;
              end else begin
                ysub <= ysub + 1'b1;
              end
              if (line_cnt == V_LAST) begin
                oFrameDone <= 1'b1;
                state      <= DONE;
              end
            end else if (de_r && de_d && (hs_r != hs_d)) begin
              // HSYNC moving inside an active line means broken timing.
              oErr <= 1'b1;
            end
          end
          DONE: begin
            if (de_rise) oErr <= 1'b1;
          end
          default: state <= WAIT_VS;
        endcase
      end

      if (pix_go) begin
        oAccEn   <= (pix_b < H_LIM) && (line_b < V_LIM);
        oZoneX   <= zx_b;
        oZoneY   <= zy_b;
        oZoneIdx <= idx_b;
        if (pix_b != '1) pix_cnt <= pix_b + 1'b1;
        if (xsub_b == XS_LAST) begin
          xsub <= '0;
          if (zx_b != ZX_LAST) zx <= zx_b + 1'b1;
        end else begin
          xsub <= xsub_b + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dim_frame_sequencer.sv
// tb_dim_frame_sequencer: scoreboard bench for dim_frame_sequencer with a
// 2x2 grid of 4x2-pixel zones (8x4 active picture).
module tb_dim_frame_sequencer;

  logic       iODCK = 1'b0;
  logic       reset;
  logic       iDE;
  logic       iHSYNC;
  logic       iVSYNC;
  logic       iSW1pass0maker;
  logic       oMode;
  logic       oAccEn;
  logic [0:0] oZoneX;
  logic [0:0] oZoneY;
  logic [1:0] oZoneIdx;
  logic       oRowLatch;
  logic       oFrameDone;
  logic       oErr;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int zx;
    int zy;
    int idx;
  } pix_t;

  pix_t pix_q[$];
  int   latch_q[$];
  pix_t mon_e;
  int   mon_l;

  int EXP_ZX[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int EXP_ZY[4] = '{0, 0, 1, 1};

  dim_frame_sequencer #(
    .ZONE_W(4), .ZONE_H(2), .ZONES_X(2), .ZONES_Y(2), .VS_POL(1'b1)
  ) dut (
    .iODCK(iODCK),
    .reset(reset),
    .iDE(iDE),
    .iHSYNC(iHSYNC),
    .iVSYNC(iVSYNC),
    .iSW1pass0maker(iSW1pass0maker),
    .oMode(oMode),
    .oAccEn(oAccEn),
    .oZoneX(oZoneX),
    .oZoneY(oZoneY),
    .oZoneIdx(oZoneIdx),
    .oRowLatch(oRowLatch),
    .oFrameDone(oFrameDone),
    .oErr(oErr)
  );

  always #5 iODCK = ~iODCK;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a pixel or a latch.
  always @(negedge iODCK) begin
    if (oAccEn === 1'b1) begin
      if (pix_q.size() == 0) begin
        check("acc_unexpected", int'(oAccEn), 0);
      end else begin
        mon_e = pix_q.pop_front();
        check("zone_x", int'(oZoneX), mon_e.zx);
        check("zone_y", int'(oZoneY), mon_e.zy);
        check("zone_idx", int'(oZoneIdx), mon_e.idx);
      end
    end
    if (oRowLatch === 1'b1) begin
      if (latch_q.size() == 0) begin
        check("row_latch_unexpected", int'(oRowLatch), 0);
      end else begin
        mon_l = latch_q.pop_front();
        check("row_latch_fd_zy", int'({oFrameDone, oZoneY}), mon_l);
      end
    end else if (oFrameDone === 1'b1) begin
      check("frame_done_without_latch", int'(oFrameDone), 0);
    end
  end

  // VSYNC pulse; checks oMode is unchanged while fs is registered and takes
  // the requested value one cycle later.
  task automatic vsync(input int mode_old, input int mode_new);
    @(negedge iODCK); iVSYNC = 1'b1;
    @(negedge iODCK); check("mode_at_fs", int'(oMode), mode_old);
    @(negedge iODCK); check("mode_after_fs", int'(oMode), mode_new);
    @(negedge iODCK); iVSYNC = 1'b0;
    repeat (2) @(negedge iODCK);
  endtask

  // One DE line. latch_exp = -1 for no oRowLatch, else {fd, zy} packed.
  task automatic line(input int n_pix, input int row, input bit acc, input int latch_exp);
    pix_t e;
    if (latch_exp >= 0) latch_q.push_back(latch_exp);
    for (int p = 0; p < n_pix; p++) begin
      @(negedge iODCK); iDE = 1'b1;
      if (acc && p < 8) begin
        e.zx  = EXP_ZX[p];
        e.zy  = EXP_ZY[row];
        e.idx = EXP_ZY[row] * 2 + EXP_ZX[p];
        pix_q.push_back(e);
      end
    end
    @(negedge iODCK); iDE = 1'b0;
    repeat (3) @(negedge iODCK);
  endtask

  task automatic frame4();
    line(8, 0, 1'b1, -1);
    line(8, 1, 1'b1, 0);
    line(8, 2, 1'b1, -1);
    line(8, 3, 1'b1, 3);
  endtask

  initial begin
    pix_t e;
    reset = 1'b1; iDE = 1'b0; iHSYNC = 1'b0; iVSYNC = 1'b0; iSW1pass0maker = 1'b1;
    repeat (3) @(negedge iODCK);
    check("rst_mode", int'(oMode), 1);
    check("rst_acc", int'(oAccEn), 0);
    check("rst_zone_x", int'(oZoneX), 0);
    check("rst_zone_y", int'(oZoneY), 0);
    check("rst_zone_idx", int'(oZoneIdx), 0);
    check("rst_row_latch", int'(oRowLatch), 0);
    check("rst_frame_done", int'(oFrameDone), 0);
    check("rst_err", int'(oErr), 0);
    reset = 1'b0;
    repeat (2) @(negedge iODCK);

    // Nominal frame; mode request changes mid-frame.
    vsync(1, 1);
    line(8, 0, 1'b1, -1);
    line(8, 1, 1'b1, 0);
    iSW1pass0maker = 1'b0;
    line(8, 2, 1'b1, -1);
    line(8, 3, 1'b1, 3);
    check("err_nominal", int'(oErr), 0);
    check("mode_held_mid_frame", int'(oMode), 1);

    // Bad line with 9 DE cycles.
    vsync(1, 0);
    line(8, 0, 1'b1, -1);
    check("err_before_bad_line", int'(oErr), 0);
    line(9, 1, 1'b1, 0);
    check("err_after_bad_line", int'(oErr), 1);
    line(8, 2, 1'b1, -1);
    line(8, 3, 1'b1, 3);
    check("err_sticky", int'(oErr), 1);
    vsync(0, 0);
    check("err_cleared_at_fs", int'(oErr), 0);

    // Short frame: three lines then VSYNC.
    line(8, 0, 1'b1, -1);
    line(8, 1, 1'b1, 0);
    line(8, 2, 1'b1, -1);
    vsync(0, 0);
    check("err_short_frame", int'(oErr), 1);
    frame4();

    // Extra line after the frame is done.
    vsync(0, 0);
    check("err_cleared_after_short", int'(oErr), 0);
    frame4();
    check("err_before_extra", int'(oErr), 0);
    line(8, 0, 1'b0, -1);
    check("err_extra_line", int'(oErr), 1);

    // Asynchronous reset in the middle of a line.
    vsync(0, 0);
    for (int p = 0; p < 4; p++) begin
      @(negedge iODCK); iDE = 1'b1;
      e.zx = EXP_ZX[p]; e.zy = 0; e.idx = EXP_ZX[p];
      pix_q.push_back(e);
    end
    repeat (2) @(negedge iODCK);
    check("acc_before_reset", int'(oAccEn), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_acc", int'(oAccEn), 0);
    check("async_rst_mode", int'(oMode), 1);
    check("async_rst_err", int'(oErr), 0);
    @(negedge iODCK);
    @(negedge iODCK); reset = 1'b0;
    repeat (3) @(negedge iODCK);
    iDE = 1'b0;
    repeat (3) @(negedge iODCK);
    line(8, 0, 1'b0, -1);
    check("err_wait_vs", int'(oErr), 0);
    check("mode_wait_vs", int'(oMode), 1);
    vsync(1, 0);
    frame4();
    check("err_final_frame", int'(oErr), 0);

    repeat (4) @(negedge iODCK);
    check("pixels_outstanding", pix_q.size(), 0);
    check("latches_outstanding", latch_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
